// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, generic width, per-operation signed/unsigned mode.
// One Booth step per clock over a WIDTH+1 bit signed datapath; start/busy/done handshake.
module booth_mult_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_signed,
   input  logic                 i_clr,
   input  logic [WIDTH-1:0]     i_mc,
   input  logic [WIDTH-1:0]     i_mp,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_prod,
   output logic [CNT_W-1:0]     o_cnt
);
   localparam int E = WIDTH + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [E-1:0]     m_reg;
   logic [E-1:0]     acc;
   logic [E-1:0]     q;
   logic             qn;
   logic [CNT_W-1:0] cnt;

   logic [E-1:0]     mc_ext;
   logic [E-1:0]     mp_ext;
   logic [E-1:0]     sum;
   logic [E-1:0]     acc_nx;
   logic [E-1:0]     q_nx;

   // One extra bit lets unsigned operands ride the same signed datapath.
   always_comb begin
      mc_ext = {i_signed & i_mc[WIDTH-1], i_mc};
      mp_ext = {i_signed & i_mp[WIDTH-1], i_mp};
      case ({q[0], qn})
         2'b01:   sum = acc + m_reg;
         2'b10:   sum = acc - m_reg;
         default: sum = acc;
      endcase
      acc_nx = {sum[E-1], sum[E-1:1]};
      q_nx   = {sum[0], q[E-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         m_reg  <= '0;
         acc    <= '0;
         q      <= '0;
         qn     <= 1'b0;
         cnt    <= '0;
         o_prod <= '0;
      end else if (i_clr) begin
         state <= S_IDLE;
         acc   <= '0;
         q     <= '0;
         qn    <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  m_reg <= mc_ext;
                  q     <= mp_ext;
                  acc   <= '0;
                  qn    <= 1'b0;
                  cnt   <= CNT_W'(E);
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               acc <= acc_nx;
               q   <= q_nx;
               qn  <= q[0];
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  // Top two bits of the 2E-bit result are sign copies and are dropped.
                  o_prod <= {acc_nx[E-3:0], q_nx};
                  state  <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_busy = (state == S_RUN);
   assign o_done = (state == S_DONE);
   assign o_cnt  = cnt;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8 plus a WIDTH=16 random regression.
module tb_booth_mult_seq;
   logic        clk;
   logic        rst;

   logic        start8, sgn8, clr8;
   logic [7:0]  mc8, mp8;
   logic        busy8, done8;
   logic [15:0] prod8;
   logic [3:0]  cnt8;

   logic        start16, sgn16, clr16;
   logic [15:0] mc16, mp16;
   logic        busy16, done16;
   logic [31:0] prod16;
   logic [4:0]  cnt16;

   int unsigned tests_run;
   int unsigned tests_failed;

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .i_start(start8), .i_signed(sgn8), .i_clr(clr8),
      .i_mc(mc8), .i_mp(mp8), .o_busy(busy8), .o_done(done8),
      .o_prod(prod8), .o_cnt(cnt8)
   );

   booth_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .i_start(start16), .i_signed(sgn16), .i_clr(clr16),
      .i_mc(mc16), .i_mp(mp16), .o_busy(busy16), .o_done(done16),
      .o_prod(prod16), .o_cnt(cnt16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge: presents operands, lets the accept edge pass, then scrambles inputs.
   task automatic launch8(input logic sgn, input logic [7:0] mc, input logic [7:0] mp);
      start8 = 1'b1;
      sgn8   = sgn;
      mc8    = mc;
      mp8    = mp;
      @(negedge clk);
      start8 = 1'b0;
      sgn8   = ~sgn;
      mc8    = 8'h5A;
      mp8    = 8'hC3;
   endtask

   // lat counts edges since the accept edge; returns at the negedge where o_done is seen.
   task automatic wait8(input int unsigned n0, output int unsigned lat, output int unsigned busy_cyc);
      lat      = n0;
      busy_cyc = 0;
      while (!done8 && lat < 40) begin
         if (busy8) busy_cyc++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int unsigned lat, bc, dones, cnt_err;
      logic [15:0] a, b;
      logic        s;
      logic [31:0] e;

      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      start8 = 1'b0; sgn8 = 1'b0; clr8 = 1'b0; mc8 = '0; mp8 = '0;
      start16 = 1'b0; sgn16 = 1'b0; clr16 = 1'b0; mc16 = '0; mp16 = '0;

      repeat (3) @(negedge clk);
      check("rst busy", busy8, 0);
      check("rst done", done8, 0);
      check("rst prod", prod8, 0);
      check("rst cnt", cnt8, 0);
      rst = 1'b0;
      @(negedge clk);

      // -7 x 3 signed
      launch8(1'b1, 8'hF9, 8'h03);
      check("first cnt", cnt8, 9);
      wait8(0, lat, bc);
      check("m7x3 lat", lat, 9);
      check("m7x3 busy", bc, 9);
      check("m7x3 prod", prod8, 16'hFFEB);
      check("m7x3 cnt0", cnt8, 0);
      @(negedge clk);
      check("done pulse", done8, 0);

      launch8(1'b1, 8'h80, 8'h80);
      wait8(0, lat, bc);
      check("s80x80 prod", prod8, 16'h4000);
      launch8(1'b0, 8'hFF, 8'hFF);
      wait8(0, lat, bc);
      check("uFFxFF prod", prod8, 16'hFE01);
      launch8(1'b0, 8'h80, 8'h02);
      wait8(0, lat, bc);
      check("u80x02 prod", prod8, 16'h0100);
      launch8(1'b1, 8'hFF, 8'hFF);
      wait8(0, lat, bc);
      check("sFFxFF prod", prod8, 16'h0001);

      // start re-pulsed in 4th RUN cycle must be ignored
      launch8(1'b1, 8'h7F, 8'h80);
      repeat (3) @(negedge clk);
      start8 = 1'b1; sgn8 = 1'b0; mc8 = 8'h01; mp8 = 8'h01;
      @(negedge clk);
      start8 = 1'b0;
      wait8(4, lat, bc);
      check("repulse lat", lat, 9);
      check("repulse prod", prod8, 16'hC080);

      // back-to-back start in the DONE cycle
      launch8(1'b0, 8'h05, 8'h06);
      check("b2b busy", busy8, 1);
      wait8(0, lat, bc);
      check("b2b lat", lat, 9);
      check("b2b prod", prod8, 16'h001E);
      @(negedge clk);

      // clear in 3rd RUN cycle
      launch8(1'b1, 8'hF9, 8'h03);
      repeat (2) @(negedge clk);
      clr8 = 1'b1;
      @(negedge clk);
      clr8 = 1'b0;
      check("clr busy", busy8, 0);
      check("clr done", done8, 0);
      check("clr cnt", cnt8, 0);
      check("clr prod", prod8, 16'h001E);
      dones = 0;
      repeat (15) begin
         if (done8) dones++;
         @(negedge clk);
      end
      check("clr no done", dones, 0);

      // async reset mid-run
      launch8(1'b1, 8'hF9, 8'h03);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst busy", busy8, 0);
      check("arst done", done8, 0);
      check("arst prod", prod8, 0);
      check("arst cnt", cnt8, 0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (15) begin
         if (done8) dones++;
         @(negedge clk);
      end
      check("arst no done", dones, 0);
      launch8(1'b1, 8'h05, 8'hFA);
      wait8(0, lat, bc);
      check("post rst prod", prod8, 16'hFFE2);

      // WIDTH=16 random regression
      cnt_err = 0;
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         s = 1'($urandom_range(0, 1));
         if (s) e = 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}));
         else   e = {16'h0000, a} * {16'h0000, b};
         start16 = 1'b1; sgn16 = s; mc16 = a; mp16 = b;
         @(negedge clk);
         start16 = 1'b0; mc16 = ~a; mp16 = ~b;
         lat = 0;
         while (!done16 && lat < 40) begin
            if (cnt16 != 5'(17 - lat)) cnt_err++;
            @(negedge clk);
            lat++;
         end
         check("w16 lat", lat, 17);
         check("w16 prod", prod16, e);
      end
      check("w16 cnt seq", cnt_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
